// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The write-hit lookup is sized for up to MAX_NWR ports and MAX_AW address bits; callers zero-pad.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int ZERO_REG = 0;
    localparam int MAX_NWR  = 8;
    localparam int MAX_AW   = 8;
    localparam int WIDX_W   = $clog2(MAX_NWR);

    typedef struct packed {
        logic              hit;
        logic [WIDX_W-1:0] idx;
    } wr_hit_t;

    // Later ports overwrite earlier matches, so the highest-index writer wins.
    function automatic wr_hit_t wr_hit(
        input logic [MAX_AW-1:0]               addr,
        input logic [MAX_NWR-1:0]              we,
        input logic [MAX_NWR-1:0][MAX_AW-1:0]  waddr
    );
        wr_hit_t r;
        r.hit = 1'b0;
        r.idx = '0;
        for (int w = 0; w < MAX_NWR; w++) begin
            if (we[w] && (waddr[w] == addr)) begin
                r.hit = 1'b1;
                r.idx = WIDX_W'(w);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: zero-register, write bypass and array mux plus busy qualification.
// Purely combinational; no backpressure.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    input  logic              ready_i,
    input  logic [NWR-1:0]    we_i,
    input  logic [NWR*AW-1:0] waddr_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0]   arr_dat_i,
    input  logic              busy_i,
    output logic [XLEN-1:0]   rdata_o,
    output logic              rbusy_o
);

    logic [MAX_NWR-1:0]             we_pad;
    logic [MAX_NWR-1:0][MAX_AW-1:0] waddr_pad;
    wr_hit_t                        hit;
    logic                           is_zero;
    logic                           byp;

    always_comb begin
        we_pad    = '0;
        waddr_pad = '0;
        for (int w = 0; w < NWR; w++) begin
            we_pad[w]    = we_i[w];
            waddr_pad[w] = MAX_AW'(waddr_i[w*AW +: AW]);
        end
        hit = wr_hit(MAX_AW'(raddr_i), we_pad, waddr_pad);
    end

    assign is_zero = (raddr_i == AW'(ZERO_REG));
    assign byp     = re_i & hit.hit;

    always_comb begin
        rdata_o = arr_dat_i;
        if (is_zero) begin
            rdata_o = '0;
        end else if (byp) begin
            rdata_o = wdata_i[int'(hit.idx)*XLEN +: XLEN];
        end
    end

    // A result being bypassed this cycle is already available, so it is not busy.
    assign rbusy_o = ready_i & ~is_zero & busy_i & ~byp;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, busy scoreboard and post-reset clear; reads zero-latency, writes land next edge.
// No backpressure: ready_o stays low during reset and the NREG-1 cycle clear sweep, when writes and issues are dropped.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int CLEAR_EN = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready_o,
    input  logic [NRD-1:0]      re_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic [NWR-1:0]      we_i,
    input  logic [NWR*AW-1:0]   waddr_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    input  logic                iss_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                flush_i
);

    logic [XLEN-1:0] regs_q [NREG];
    state_e          state_q;
    logic [AW-1:0]   ptr_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            ready_q;

    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (we_i[w]) begin
                busy_d[waddr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_i) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= AW'(1);
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    busy_q <= '0;
                    if ((CLEAR_EN == 0) || (ptr_q == AW'(NREG-1))) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                RUN: begin
                    busy_q <= busy_d;
                end
            endcase
        end
    end

    // Data storage carries no reset; the clear sweep is the only initialiser.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                if (CLEAR_EN != 0) begin
                    regs_q[ptr_q] <= '0;
                end
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (we_i[w] && (waddr_i[w*AW +: AW] != AW'(ZERO_REG))) begin
                        regs_q[waddr_i[w*AW +: AW]] <= wdata_i[w*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    assign ready_o = ready_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr_i[p*AW +: AW];

        regfile_rdport #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_rdport (
            .re_i      (re_i[p]),
            .raddr_i   (ra),
            .ready_i   (ready_q),
            .we_i      (we_i),
            .waddr_i   (waddr_i),
            .wdata_i   (wdata_i),
            .arr_dat_i (regs_q[ra]),
            .busy_i    (busy_q[ra]),
            .rdata_o   (rdata_o[p*XLEN +: XLEN]),
            .rbusy_o   (rbusy_o[p])
        );
    end

endmodule
